// File: rtl/comma_aligner_if.sv
// Word-level bus between the deserializer front end and the 8b/10b decoder.
interface comma_aligner_if;
  logic [9:0] RxRaw_10;
  logic       decode_error;
  logic [9:0] RxParallel_10;
  logic       comma_det;
  logic       byte_aligned;
  logic [3:0] align_offset;

  modport master (
    output RxRaw_10, decode_error,
    input  RxParallel_10, comma_det, byte_aligned, align_offset
  );
  modport slave (
    input  RxRaw_10, decode_error,
    output RxParallel_10, comma_det, byte_aligned, align_offset
  );
endinterface

// File: rtl/comma_aligner.sv
// K28.5 comma aligner: finds the 10-bit symbol boundary in the raw
// deserializer stream, confirms it, and holds it while the decoder is happy.
module comma_aligner #(
  parameter int ACQ_TIMEOUT = 255,
  parameter int ERR_LIMIT   = 4,
  parameter int GOOD_RUN    = 8
) (
  input  logic           BitCLK_10,
  input  logic           Reset,
  comma_aligner_if.slave bus
);
  localparam int TW = $clog2(ACQ_TIMEOUT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);
  localparam logic [9:0] K_RDN = 10'h17C;
  localparam logic [9:0] K_RDP = 10'h283;

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

  state_t        r_state;
  logic [9:0]    r_prev_raw;
  logic [9:0]    r_par;
  logic          r_cd;
  logic          r_ba;
  logic [3:0]    r_off;
  logic [TW-1:0] r_timer;
  logic [EW-1:0] r_err;
  logic [GW-1:0] r_good;

  // Window is {current, previous}; the top raw bit can never fall inside a
  // 10-bit slice starting at offset 0..9, so it is left out of the window.
  logic [18:0] w_win;
  logic [9:0]  w_match;
  logic        w_any;
  logic [3:0]  w_first;
  logic [9:0]  w_sel;
  logic        w_hit;

  assign w_win = {bus.RxRaw_10[8:0], r_prev_raw};

  for (genvar k = 0; k < 10; k++) begin : g_cmp
    assign w_match[k] = (w_win[k+9:k] == K_RDN) || (w_win[k+9:k] == K_RDP);
  end

  // Lowest matching offset wins when several offsets carry a comma.
  always_comb begin
    w_any   = 1'b0;
    w_first = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (w_match[k]) begin
        w_any   = 1'b1;
        w_first = 4'(k);
      end
    end
  end

  assign w_sel = w_win[r_off +: 10];
  assign w_hit = w_match[r_off];

  // Datapath registers plus HUNT/ACQUIRE/LOCKED alignment state machine.
  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      r_state    <= HUNT;
      r_prev_raw <= '0;
      r_par      <= '0;
      r_cd       <= 1'b0;
      r_ba       <= 1'b0;
      r_off      <= '0;
      r_timer    <= '0;
      r_err      <= '0;
      r_good     <= '0;
    end else begin
      r_prev_raw <= bus.RxRaw_10;
      r_par      <= w_sel;
      r_cd       <= w_hit;
      case (r_state)
        HUNT: begin
          if (w_any) begin
            r_off   <= w_first;
            r_timer <= '0;
            r_state <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (w_hit) begin
            r_state <= LOCKED;
            r_ba    <= 1'b1;
            r_err   <= '0;
            r_good  <= '0;
          end else if (w_any) begin
            r_off   <= w_first;
            r_timer <= '0;
          end else if (r_timer >= TW'(ACQ_TIMEOUT - 1)) begin
            // give up; offset is kept, the next HUNT comma overwrites it
            r_state <= HUNT;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        LOCKED: begin
          // offset frozen; commas elsewhere are ignored, only decoder health matters
          if (bus.decode_error) begin
            r_good <= '0;
            if (r_err >= EW'(ERR_LIMIT - 1)) begin
              r_state <= HUNT;
              r_ba    <= 1'b0;
              r_err   <= '0;
            end else begin
              r_err <= r_err + 1'b1;
            end
          end else if (r_good >= GW'(GOOD_RUN - 1)) begin
            r_good <= '0;
            if (r_err != '0) r_err <= r_err - 1'b1;
          end else begin
            r_good <= r_good + 1'b1;
          end
        end
        default: begin
          r_state <= HUNT;
          r_ba    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RxParallel_10 = r_par;
  assign bus.comma_det     = r_cd;
  assign bus.byte_aligned  = r_ba;
  assign bus.align_offset  = r_off;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: directed scenarios plus a randomized symbol
// stream, all checked against a word-level behavioural model.
module tb_comma_aligner;
  localparam int ACQ_T  = 255;
  localparam int ERR_L  = 4;
  localparam int GOOD_R = 8;
  localparam logic [9:0] K_N = 10'h17C;
  localparam logic [9:0] K_P = 10'h283;
  localparam logic [9:0] D00 = 10'h0B9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  comma_aligner_if bus();

  comma_aligner #(.ACQ_TIMEOUT(ACQ_T), .ERR_LIMIT(ERR_L), .GOOD_RUN(GOOD_R)) dut (
    .BitCLK_10 (clk),
    .Reset     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  string phase = "por";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_HUNT, M_ACQ, M_LOCK} mst_t;
  mst_t       m_st;
  int         m_off, m_wait, m_errs, m_clean;
  logic [9:0] m_prev, m_par;
  bit         m_cd, m_ba;

  function automatic bit comma_at(input logic [9:0] hi, input logic [9:0] lo, input int k);
    logic [9:0] s;
    s = 10'({hi, lo} >> k);
    return (s == K_N) || (s == K_P);
  endfunction

  function automatic int first_comma(input logic [9:0] hi, input logic [9:0] lo);
    for (int k = 0; k < 10; k++) if (comma_at(hi, lo, k)) return k;
    return -1;
  endfunction

  task automatic m_reset();
    m_st = M_HUNT; m_off = 0; m_wait = 0; m_errs = 0; m_clean = 0;
    m_prev = '0; m_par = '0; m_cd = 0; m_ba = 0;
  endtask

  task automatic m_step(input logic [9:0] raw, input bit de);
    int f;
    bit here;
    f     = first_comma(raw, m_prev);
    here  = comma_at(raw, m_prev, m_off);
    m_par = 10'({raw, m_prev} >> m_off);
    m_cd  = here;
    m_prev = raw;
    case (m_st)
      M_HUNT: if (f >= 0) begin m_off = f; m_wait = 0; m_st = M_ACQ; end
      M_ACQ: begin
        if (here) begin m_st = M_LOCK; m_errs = 0; m_clean = 0; end
        else if (f >= 0) begin m_off = f; m_wait = 0; end
        else begin
          m_wait++;
          if (m_wait >= ACQ_T) begin m_st = M_HUNT; m_wait = 0; end
        end
      end
      M_LOCK: begin
        if (de) begin
          m_clean = 0;
          m_errs++;
          if (m_errs >= ERR_L) m_st = M_HUNT;
        end else begin
          m_clean++;
          if (m_clean >= GOOD_R) begin
            m_clean = 0;
            if (m_errs > 0) m_errs--;
          end
        end
      end
      default: m_st = M_HUNT;
    endcase
    m_ba = (m_st == M_LOCK);
  endtask

  // ---------------- stimulus helpers ----------------
  bit bq[$];

  task automatic cyc(input logic [9:0] raw, input bit de);
    bus.RxRaw_10     = raw;
    bus.decode_error = de;
    @(posedge clk);
    m_step(raw, de);
    #1;
    chk({phase, ".par"},  32'(bus.RxParallel_10), 32'(m_par));
    chk({phase, ".cdet"}, 32'(bus.comma_det),     32'(m_cd));
    chk({phase, ".ba"},   32'(bus.byte_aligned),  32'(m_ba));
    chk({phase, ".off"},  32'(bus.align_offset),  32'(m_off));
  endtask

  task automatic push(input logic [9:0] s, input int n);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 10; b++) bq.push_back(s[b]);
  endtask

  task automatic pushbits(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) bq.push_back(v[i]);
  endtask

  task automatic flush(input bit de);
    logic [9:0] w;
    while (bq.size() >= 10) begin
      for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
      cyc(w, de);
    end
  endtask

  task automatic dword(input bit de);
    push(D00, 1);
    flush(de);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk({phase, ".rst_par"},  32'(bus.RxParallel_10), 32'h0);
    chk({phase, ".rst_cdet"}, 32'(bus.comma_det),     32'h0);
    chk({phase, ".rst_ba"},   32'(bus.byte_aligned),  32'h0);
    chk({phase, ".rst_off"},  32'(bus.align_offset),  32'h0);
    m_reset();
    bq.delete();
    bus.RxRaw_10     = '0;
    bus.decode_error = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // lock at offset 3: 3 lead bits, 5 x D0.0, 2 x K28.5, 1 x D0.0
  task automatic lock3();
    pushbits(3, 0);
    push(D00, 5);
    push(K_N, 2);
    push(D00, 1);
    flush(0);
    chk({phase, ".lock3_ba"},  32'(bus.byte_aligned), 32'h1);
    chk({phase, ".lock3_off"}, 32'(bus.align_offset), 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.RxRaw_10     = '0;
    bus.decode_error = 1'b0;
    m_reset();
    #12;
    chk("por.par",  32'(bus.RxParallel_10), 32'h0);
    chk("por.cdet", 32'(bus.comma_det),     32'h0);
    chk("por.ba",   32'(bus.byte_aligned),  32'h0);
    chk("por.off",  32'(bus.align_offset),  32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // shifted K28.5 stream after D0.0 preamble
    phase = "shift3";
    pushbits(3, 0);
    push(D00, 5);
    push(K_N, 2);
    flush(0);
    chk("shift3.acq_off", 32'(bus.align_offset), 32'd3);
    chk("shift3.acq_ba",  32'(bus.byte_aligned), 32'h0);
    push(K_N, 4);
    flush(0);
    chk("shift3.lock_ba",  32'(bus.byte_aligned),  32'h1);
    chk("shift3.lock_off", 32'(bus.align_offset),  32'd3);
    chk("shift3.par",      32'(bus.RxParallel_10), 32'h17C);
    chk("shift3.cdet",     32'(bus.comma_det),     32'h1);

    // comma moves from offset 3 to 7 during ACQUIRE
    phase = "reload";
    do_reset();
    pushbits(3, 0);
    push(D00, 5);
    push(K_N, 1);
    push(D00, 1);
    flush(0);
    chk("reload.off3", 32'(bus.align_offset), 32'd3);
    pushbits(4, 0);
    push(D00, 1);
    push(K_N, 1);
    push(D00, 1);
    flush(0);
    chk("reload.off7", 32'(bus.align_offset), 32'd7);
    chk("reload.ba0",  32'(bus.byte_aligned), 32'h0);
    push(K_N, 1);
    push(D00, 2);
    flush(0);
    chk("reload.ba1",  32'(bus.byte_aligned), 32'h1);
    chk("reload.off",  32'(bus.align_offset), 32'd7);

    // one comma then silence: acquisition times out
    phase = "timeout";
    do_reset();
    pushbits(3, 0);
    push(D00, 5);
    push(K_N, 1);
    push(D00, 260);
    flush(0);
    chk("timeout.ba", 32'(bus.byte_aligned), 32'h0);
    push(K_N, 1);
    push(D00, 1);
    flush(0);
    chk("timeout.hunt_ba", 32'(bus.byte_aligned), 32'h0);
    push(K_N, 1);
    push(D00, 1);
    flush(0);
    chk("timeout.relock", 32'(bus.byte_aligned), 32'h1);

    // four spaced errors drop the lock
    phase = "errs4";
    do_reset();
    lock3();
    dword(1); dword(0); dword(0);
    dword(1); repeat (5) dword(0);
    dword(1); repeat (7) dword(0);
    chk("errs4.before", 32'(bus.byte_aligned), 32'h1);
    dword(1);
    chk("errs4.after", 32'(bus.byte_aligned), 32'h0);

    // clean run forgives errors
    phase = "forgive";
    do_reset();
    lock3();
    repeat (3) dword(1);
    repeat (24) dword(0);
    repeat (3) dword(1);
    chk("forgive.ba", 32'(bus.byte_aligned), 32'h1);
    dword(1);
    chk("forgive.drop", 32'(bus.byte_aligned), 32'h0);

    // reset in the middle of a lock, relock at offset 9
    phase = "midrst";
    do_reset();
    lock3();
    repeat (3) dword(0);
    chk("midrst.pre", 32'(bus.byte_aligned), 32'h1);
    do_reset();
    pushbits(9, 0);
    push(D00, 5);
    push(K_N, 3);
    flush(0);
    chk("midrst.off", 32'(bus.align_offset), 32'd9);
    chk("midrst.ba",  32'(bus.byte_aligned), 32'h1);

    // commas at offsets 0 and 9 at once: lowest wins
    phase = "prio";
    do_reset();
    cyc(10'h17C, 0);
    cyc(10'h0BE, 0);
    chk("prio.off", 32'(bus.align_offset), 32'd0);

    // randomized symbol stream with bit slips and decoder errors
    phase = "rand";
    do_reset();
    for (int blk = 0; blk < 4; blk++) begin
      int errp;
      errp = (blk == 0) ? 0 : (blk == 1) ? 5 : (blk == 2) ? 15 : 30;
      for (int i = 0; i < 350; i++) begin
        int r;
        bit de;
        r  = $urandom_range(0, 99);
        de = ($urandom_range(0, 99) < errp);
        if (r < 30)      push($urandom_range(0, 1) ? K_P : K_N, 1);
        else if (r < 33) pushbits($urandom_range(1, 9), $urandom);
        else if (r < 60) push(D00, 1);
        else             push(10'($urandom_range(0, 1023)), 1);
        flush(de);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/comma_aligner.md
COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 Parameter ACQ_TIMEOUT, default 255; the maximum number of words ACQUIRE waits for a confirming comma.
REQ-002 Parameter ERR_LIMIT, default 4; the number of code errors in LOCKED that forces HUNT.
REQ-003 Parameter GOOD_RUN, default 8; the number of consecutive error-free LOCKED words that forgives one error.
REQ-004 BitCLK_10 input 1: word clock, rising edge.
REQ-005 Reset input 1: asynchronous, active-low reset.
REQ-006 RxRaw_10 input 10: unaligned deserializer word; bit0 is the earliest received bit.
REQ-007 decode_error input 1: code-error flag from the downstream 8b/10b decoder, sampled each cycle.
REQ-008 RxParallel_10 output 10: aligned word for the decoder; bit0 = a, bit9 = j.
REQ-009 comma_det output 1: K28.5 found at the current align_offset in the emitted word.
REQ-010 byte_aligned output 1: high only in LOCKED.
REQ-011 align_offset output 4: current bit offset, 0..9.

Function
REQ-012 The block SHALL register the previous raw word and form window W[19:0] = {RxRaw_10, prev_raw}.
REQ-013 A comma at offset k (0..9) SHALL be W[k+9:k] equal to 10'h17C (RD-) or 10'h283 (RD+).
REQ-014 When commas are present at several offsets, the lowest k SHALL win.
REQ-015 Each edge SHALL register RxParallel_10 <= W[align_offset+9:align_offset] using the pre-edge align_offset.
REQ-016 The total latency from a raw word to its aligned output SHALL be 2 cycles.
REQ-017 comma_det SHALL register alongside RxParallel_10 and assert only when the match is at the pre-edge align_offset.
REQ-018 The FSM SHALL have the states HUNT, ACQUIRE and LOCKED.
REQ-019 HUNT: a comma at any k SHALL load align_offset <= k, clear the timer and go to ACQUIRE; otherwise the FSM SHALL stay in HUNT.
REQ-020 ACQUIRE: a comma at the held offset SHALL go to LOCKED and clear err_cnt and good_cnt.
REQ-021 ACQUIRE: a comma at a different offset SHALL reload align_offset, clear the timer and stay in ACQUIRE.
REQ-022 ACQUIRE: when the timer reaches ACQ_TIMEOUT with no confirming comma, the FSM SHALL go to HUNT and keep align_offset.
REQ-023 LOCKED: decode_error=1 SHALL increment err_cnt and clear good_cnt.
REQ-024 LOCKED: when err_cnt reaches ERR_LIMIT, the FSM SHALL go to HUNT on that edge.
REQ-025 LOCKED: a clean word SHALL increment good_cnt.
REQ-026 LOCKED: when good_cnt reaches GOOD_RUN, err_cnt SHALL decrement (saturating at 0) and good_cnt SHALL clear.
REQ-027 LOCKED: align_offset SHALL stay frozen; commas at other offsets SHALL be ignored.
REQ-028 decode_error SHALL be ignored in HUNT and ACQUIRE.
REQ-029 Simultaneous decode_error and an aligned comma SHALL count as an error.
REQ-030 byte_aligned SHALL be 1 in LOCKED and 0 in HUNT and ACQUIRE.
REQ-031 byte_aligned SHALL deassert on the same edge that enters HUNT.
REQ-032 All counters SHALL saturate and never wrap.

Reset
REQ-033 Reset low SHALL immediately force HUNT and clear prev_raw, RxParallel_10, comma_det, byte_aligned, align_offset, the timer, err_cnt and good_cnt to 0.
REQ-034 A reset asserted mid-LOCKED SHALL discard the lock; after release, alignment SHALL restart from HUNT.

Verification
REQ-035 Stream of K28.5 RD- shifted by 3 bits, preceded by 5 D0.0 words -> align_offset=3 after the 1st comma; byte_aligned=1 after the 2nd; RxParallel_10=10'h17C with comma_det=1 two cycles after each comma.
REQ-036 Comma at offset 3, then the next comma at offset 7 -> ACQUIRE reloads align_offset=7; the next comma at 7 gives LOCKED.
REQ-037 Single comma followed by 255 non-comma words -> return to HUNT, byte_aligned stays 0.
REQ-038 LOCKED; decode_error pulsed on 4 non-consecutive cycles with gaps <8 -> HUNT on the 4th, byte_aligned=0 the same edge.
REQ-039 LOCKED; 3 errors, then 24 clean words, then 3 more errors -> stays LOCKED (err_cnt 3->0->3).
REQ-040 Reset low mid-LOCKED -> all outputs 0 immediately; after release, the comma sequence relocks at a new offset 9.
